vic_nested: RTL and testbench

- Parametrised nested vectored interrupt controller; successor to the flat 31-source Vic.
- Sits beside the CPU fetch stage: sources are i_ext lines, the core supplies PC/condition codes and a return strobe.
- Adds per-source priority, edge/level mode and preemption.
- Keeps a hardware stack of interrupted PC/condition codes; o_VIC_ctrl redirects fetch to o_VIC_iaddr.

---
 rtl/vic_nested.sv | 174 +++++++++++++++++
 tb/tb_vic_nested.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vic_nested.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vic_nested : nested vectored interrupt controller with PC/CC save stack  |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module vic_nested #(
  parameter int                N_SRC      = 31,
  parameter int                PRIO_W     = 2,
  parameter int                NEST_DEPTH = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 'h0000_0100,
  parameter int                VEC_STRIDE = 4,
  localparam int               DATA_W     = PRIO_W + 2,
  localparam int               DEPTH_W    = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  i_PC,
  input  logic [3:0]         i_CCodes,
  input  logic [DATA_W-1:0]  i_VIC_data,
  input  logic [4:0]         i_VIC_regaddr,
  input  logic               i_VIC_we,
  input  logic [N_SRC-1:0]   i_ext,
  input  logic               i_reti,
  output logic [DATA_W-1:0]  o_VIC_data,
  output logic [ADDR_W-1:0]  o_VIC_iaddr,
  output logic               o_VIC_ctrl,
  output logic               o_VIC_ret,
  output logic [3:0]         o_CCodes,
  output logic [DEPTH_W-1:0] o_nest_depth
);

  localparam logic [4:0] GEN_ADDR = 5'd31;

  // Per-source config word: {prio, mode, enable}
  logic [DATA_W-1:0]  cfg_q [N_SRC];
  logic               gen_q;
  logic [N_SRC-1:0]   ext_prev_q;
  logic [N_SRC-1:0]   pending_q, pending_d;

  logic [ADDR_W-1:0]  stk_pc_q   [NEST_DEPTH];
  logic [3:0]         stk_cc_q   [NEST_DEPTH];
  logic [PRIO_W-1:0]  stk_prio_q [NEST_DEPTH];
  logic [DEPTH_W-1:0] depth_q;

  logic               ctrl_q, ret_q;
  logic [ADDR_W-1:0]  iaddr_q;
  logic [3:0]         cc_q;

  logic [ADDR_W-1:0]  top_pc;
  logic [3:0]         top_cc;
  logic [PRIO_W-1:0]  top_prio;

  logic               win_valid;
  logic [4:0]         win_idx;
  logic [PRIO_W-1:0]  win_prio;

  logic               do_ret, do_take;

  always_comb begin
    top_pc   = '0;
    top_cc   = '0;
    top_prio = '0;
    for (int e = 0; e < NEST_DEPTH; e++) begin
      if (depth_q == DEPTH_W'(e + 1)) begin
        top_pc   = stk_pc_q[e];
        top_cc   = stk_cc_q[e];
        top_prio = stk_prio_q[e];
      end
    end
  end

  // Strict greater-than keeps the lowest index on priority ties.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (pending_q[k] && cfg_q[k][0] &&
          (depth_q == '0 || cfg_q[k][DATA_W-1:2] > top_prio)) begin
        if (!win_valid || cfg_q[k][DATA_W-1:2] > win_prio) begin
          win_valid = 1'b1;
          win_idx   = 5'(k);
          win_prio  = cfg_q[k][DATA_W-1:2];
        end
      end
    end
  end

  // A return always beats a take; the popped level is re-arbitrated next cycle.
  assign do_ret  = i_reti && (depth_q != '0);
  assign do_take = !do_ret && win_valid && gen_q && (depth_q < DEPTH_W'(NEST_DEPTH));

  always_comb begin
    pending_d = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (cfg_q[k][1]) begin
        pending_d[k] = (pending_q[k] & ~(do_take && win_idx == 5'(k)))
                     | (i_ext[k] & ~ext_prev_q[k]);
      end else begin
        pending_d[k] = i_ext[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_SRC; k++) cfg_q[k] <= '0;
      for (int e = 0; e < NEST_DEPTH; e++) begin
        stk_pc_q[e]   <= '0;
        stk_cc_q[e]   <= '0;
        stk_prio_q[e] <= '0;
      end
      gen_q      <= 1'b0;
      ext_prev_q <= '0;
      pending_q  <= '0;
      depth_q    <= '0;
      ctrl_q     <= 1'b0;
      ret_q      <= 1'b0;
      iaddr_q    <= '0;
      cc_q       <= '0;
    end else begin
      ext_prev_q <= i_ext;
      pending_q  <= pending_d;

      if (i_VIC_we) begin
        for (int k = 0; k < N_SRC; k++) begin
          if (i_VIC_regaddr == 5'(k)) cfg_q[k] <= i_VIC_data;
        end
        if (i_VIC_regaddr == GEN_ADDR) gen_q <= i_VIC_data[0];
      end

      ctrl_q  <= 1'b0;
      ret_q   <= 1'b0;
      iaddr_q <= '0;
      cc_q    <= '0;

      if (do_ret) begin
        ctrl_q  <= 1'b1;
        ret_q   <= 1'b1;
        iaddr_q <= top_pc;
        cc_q    <= top_cc;
        depth_q <= depth_q - 1'b1;
      end else if (do_take) begin
        ctrl_q  <= 1'b1;
        iaddr_q <= VEC_BASE + ADDR_W'(win_idx) * ADDR_W'(VEC_STRIDE);
        depth_q <= depth_q + 1'b1;
        for (int e = 0; e < NEST_DEPTH; e++) begin
          if (depth_q == DEPTH_W'(e)) begin
            stk_pc_q[e]   <= i_PC;
            stk_cc_q[e]   <= i_CCodes;
            stk_prio_q[e] <= win_prio;
          end
        end
      end
    end
  end

  always_comb begin
    o_VIC_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (i_VIC_regaddr == 5'(k)) o_VIC_data = cfg_q[k];
    end
    if (i_VIC_regaddr == GEN_ADDR) o_VIC_data = DATA_W'(gen_q);
  end

  assign o_VIC_ctrl   = ctrl_q;
  assign o_VIC_ret    = ret_q;
  assign o_VIC_iaddr  = iaddr_q;
  assign o_CCodes     = cc_q;
  assign o_nest_depth = depth_q;

endmodule
`default_nettype wire

// File: tb/tb_vic_nested.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vic_nested : directed bench for vic_nested (NEST_DEPTH=2 instance)    |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_vic_nested;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_PC;
  logic [3:0]  i_CCodes;
  logic [3:0]  i_VIC_data;
  logic [4:0]  i_VIC_regaddr;
  logic        i_VIC_we;
  logic [30:0] i_ext;
  logic        i_reti;
  logic [3:0]  o_VIC_data;
  logic [31:0] o_VIC_iaddr;
  logic        o_VIC_ctrl;
  logic        o_VIC_ret;
  logic [3:0]  o_CCodes;
  logic [1:0]  o_nest_depth;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vic_nested #(.NEST_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .i_PC(i_PC), .i_CCodes(i_CCodes),
    .i_VIC_data(i_VIC_data), .i_VIC_regaddr(i_VIC_regaddr), .i_VIC_we(i_VIC_we),
    .i_ext(i_ext), .i_reti(i_reti), .o_VIC_data(o_VIC_data),
    .o_VIC_iaddr(o_VIC_iaddr), .o_VIC_ctrl(o_VIC_ctrl), .o_VIC_ret(o_VIC_ret),
    .o_CCodes(o_CCodes), .o_nest_depth(o_nest_depth)
  );

  // Packed observation: {ctrl, ret, iaddr, ccodes, depth}
  function automatic logic [39:0] obs();
    return {o_VIC_ctrl, o_VIC_ret, o_VIC_iaddr, o_CCodes, o_nest_depth};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] d);
    i_VIC_regaddr = a;
    i_VIC_data    = d;
    i_VIC_we      = 1'b1;
    tick();
    i_VIC_we      = 1'b0;
  endtask

  task automatic pulse(input logic [30:0] m);
    i_ext = m;
    tick();
    i_ext = '0;
  endtask

  task automatic reti();
    i_reti = 1'b1;
    tick();
    i_reti = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      i_VIC_regaddr = 5'(a);
      #1;
      n_chk++;
      if (o_VIC_data !== 4'h0) begin
        n_fail++; $display("FAIL reset_read[%0d]: got %h want 0", a, o_VIC_data);
      end
    end
    n_chk++;
    if (obs() !== 40'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs()); end
  endtask

  task automatic test_gen_enable_take();
    wr(5'd3, 4'b0111);
    i_PC = 32'h40; i_CCodes = 4'hA;
    pulse(31'(1) << 3);
    tick();
    n_chk++;
    if (o_VIC_ctrl !== 1'b0) begin n_fail++; $display("FAIL gen_off_notake: got %b want 0", o_VIC_ctrl); end
    wr(5'd31, 4'h1);
    n_chk++;
    if (o_VIC_ctrl !== 1'b0) begin n_fail++; $display("FAIL gen_write_old_value: got %b want 0", o_VIC_ctrl); end
    tick();
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 32'h10C, 4'h0, 2'd1}) begin
      n_fail++; $display("FAIL take_src3: got %h want %h", obs(), {1'b1, 1'b0, 32'h10C, 4'h0, 2'd1});
    end
    tick();
    n_chk++;
    if (obs() !== {1'b0, 1'b0, 32'h0, 4'h0, 2'd1}) begin
      n_fail++; $display("FAIL take_src3_pulse_end: got %h want %h", obs(), {1'b0, 1'b0, 32'h0, 4'h0, 2'd1});
    end
    i_VIC_regaddr = 5'd3; #1;
    n_chk++;
    if (o_VIC_data !== 4'b0111) begin n_fail++; $display("FAIL read_cfg3: got %h want 7", o_VIC_data); end
    i_VIC_regaddr = 5'd31; #1;
    n_chk++;
    if (o_VIC_data !== 4'h1) begin n_fail++; $display("FAIL read_gen: got %h want 1", o_VIC_data); end
  endtask

  task automatic test_nest();
    wr(5'd7, 4'b1111);
    i_PC = 32'h120; i_CCodes = 4'h5;
    pulse(31'(1) << 7);
    tick();
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 32'h11C, 4'h0, 2'd2}) begin
      n_fail++; $display("FAIL nest_take_src7: got %h want %h", obs(), {1'b1, 1'b0, 32'h11C, 4'h0, 2'd2});
    end
    tick();
    reti();
    n_chk++;
    if (obs() !== {1'b1, 1'b1, 32'h120, 4'h5, 2'd1}) begin
      n_fail++; $display("FAIL nest_ret1: got %h want %h", obs(), {1'b1, 1'b1, 32'h120, 4'h5, 2'd1});
    end
    tick();
    n_chk++;
    if (obs() !== {1'b0, 1'b0, 32'h0, 4'h0, 2'd1}) begin
      n_fail++; $display("FAIL nest_ret1_pulse_end: got %h want %h", obs(), {1'b0, 1'b0, 32'h0, 4'h0, 2'd1});
    end
    reti();
    n_chk++;
    if (obs() !== {1'b1, 1'b1, 32'h40, 4'hA, 2'd0}) begin
      n_fail++; $display("FAIL nest_ret2: got %h want %h", obs(), {1'b1, 1'b1, 32'h40, 4'hA, 2'd0});
    end
    tick();
  endtask

  task automatic test_preempt();
    i_PC = 32'h40; i_CCodes = 4'hA;
    pulse(31'(1) << 3);
    tick();
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 32'h10C, 4'h0, 2'd1}) begin
      n_fail++; $display("FAIL pre_take_src3: got %h want %h", obs(), {1'b1, 1'b0, 32'h10C, 4'h0, 2'd1});
    end
    wr(5'd5, 4'b0111);
    pulse(31'(1) << 5);
    tick();
    n_chk++;
    if (obs() !== {1'b0, 1'b0, 32'h0, 4'h0, 2'd1}) begin
      n_fail++; $display("FAIL equal_prio_no_preempt: got %h want %h", obs(), {1'b0, 1'b0, 32'h0, 4'h0, 2'd1});
    end
    i_PC = 32'h200;
    reti();
    n_chk++;
    if (obs() !== {1'b1, 1'b1, 32'h40, 4'hA, 2'd0}) begin
      n_fail++; $display("FAIL tail_ret: got %h want %h", obs(), {1'b1, 1'b1, 32'h40, 4'hA, 2'd0});
    end
    tick();
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 32'h114, 4'h0, 2'd1}) begin
      n_fail++; $display("FAIL tail_take_src5: got %h want %h", obs(), {1'b1, 1'b0, 32'h114, 4'h0, 2'd1});
    end
    reti();
    n_chk++;
    if (obs() !== {1'b1, 1'b1, 32'h200, 4'hA, 2'd0}) begin
      n_fail++; $display("FAIL ret_src5: got %h want %h", obs(), {1'b1, 1'b1, 32'h200, 4'hA, 2'd0});
    end
    tick();
  endtask

  task automatic test_tie();
    wr(5'd2, 4'b1011);
    wr(5'd9, 4'b1011);
    i_PC = 32'h300; i_CCodes = 4'h3;
    pulse((31'(1) << 2) | (31'(1) << 9));
    tick();
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 32'h108, 4'h0, 2'd1}) begin
      n_fail++; $display("FAIL tie_low_index: got %h want %h", obs(), {1'b1, 1'b0, 32'h108, 4'h0, 2'd1});
    end
    tick();
    n_chk++;
    if (o_VIC_ctrl !== 1'b0) begin n_fail++; $display("FAIL tie_loser_waits: got %b want 0", o_VIC_ctrl); end
    reti();
    n_chk++;
    if (obs() !== {1'b1, 1'b1, 32'h300, 4'h3, 2'd0}) begin
      n_fail++; $display("FAIL tie_ret: got %h want %h", obs(), {1'b1, 1'b1, 32'h300, 4'h3, 2'd0});
    end
    tick();
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 32'h124, 4'h0, 2'd1}) begin
      n_fail++; $display("FAIL tie_take_src9: got %h want %h", obs(), {1'b1, 1'b0, 32'h124, 4'h0, 2'd1});
    end
    reti();
    tick();
  endtask

  task automatic test_stack_full();
    i_PC = 32'h40; i_CCodes = 4'hA;
    pulse(31'(1) << 3);
    tick();
    i_PC = 32'h80; i_CCodes = 4'h6;
    pulse(31'(1) << 2);
    tick();
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 32'h108, 4'h0, 2'd2}) begin
      n_fail++; $display("FAIL full_second_take: got %h want %h", obs(), {1'b1, 1'b0, 32'h108, 4'h0, 2'd2});
    end
    pulse(31'(1) << 7);
    tick();
    tick();
    n_chk++;
    if (obs() !== {1'b0, 1'b0, 32'h0, 4'h0, 2'd2}) begin
      n_fail++; $display("FAIL full_blocks_take: got %h want %h", obs(), {1'b0, 1'b0, 32'h0, 4'h0, 2'd2});
    end
    reti();
    n_chk++;
    if (obs() !== {1'b1, 1'b1, 32'h80, 4'h6, 2'd1}) begin
      n_fail++; $display("FAIL full_ret: got %h want %h", obs(), {1'b1, 1'b1, 32'h80, 4'h6, 2'd1});
    end
    tick();
    n_chk++;
    if (obs() !== {1'b1, 1'b0, 32'h11C, 4'h0, 2'd2}) begin
      n_fail++; $display("FAIL full_then_take_src7: got %h want %h", obs(), {1'b1, 1'b0, 32'h11C, 4'h0, 2'd2});
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    n_chk++;
    if (obs() !== 40'h0) begin n_fail++; $display("FAIL midreset_outputs: got %h want 0", obs()); end
    i_VIC_regaddr = 5'd7; #1;
    n_chk++;
    if (o_VIC_data !== 4'h0) begin n_fail++; $display("FAIL midreset_cfg7: got %h want 0", o_VIC_data); end
    i_VIC_regaddr = 5'd31; #1;
    n_chk++;
    if (o_VIC_data !== 4'h0) begin n_fail++; $display("FAIL midreset_gen: got %h want 0", o_VIC_data); end
    rst = 1'b0;
  endtask

  task automatic test_reti_empty();
    reti();
    n_chk++;
    if (obs() !== 40'h0) begin n_fail++; $display("FAIL reti_empty: got %h want 0", obs()); end
    tick();
    n_chk++;
    if (obs() !== 40'h0) begin n_fail++; $display("FAIL reti_empty_after: got %h want 0", obs()); end
  endtask

  initial begin
    rst = 1'b1; i_PC = '0; i_CCodes = '0; i_VIC_data = '0; i_VIC_regaddr = '0;
    i_VIC_we = 1'b0; i_ext = '0; i_reti = 1'b0;
    test_reset();
    test_gen_enable_take();
    test_nest();
    test_preempt();
    test_tie();
    test_stack_full();
    test_reset_mid();
    test_reti_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
